// File: rtl/rst_sync_bridge.sv
// Reset synchronizer: asserts asynchronously, deasserts after NUM_STAGES clk edges.
// Optional RST_SYNC_DONE_PULSE_EN adds rst_done, a one-cycle pulse on the release edge.
module rst_sync_bridge #(
  parameter int NUM_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  output logic sync_rst,
  output logic sync_rst_n
`ifdef RST_SYNC_DONE_PULSE_EN
  ,
  output logic rst_done
`endif
);

  // Out-of-range depths are clamped to the nearest legal depth (2..8).
  localparam int STAGES = (NUM_STAGES < 2) ? 2 :
                          (NUM_STAGES > 8) ? 8 : NUM_STAGES;

  logic [STAGES-1:0] stage;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage <= '1;
    end else begin
      stage <= {stage[STAGES-2:0], 1'b0};
    end
  end

  assign sync_rst   = stage[STAGES-1];
  assign sync_rst_n = ~sync_rst;

`ifdef RST_SYNC_DONE_PULSE_EN
  // Registered falling-edge detect: the output stage is still 1 but will load the 0 from stage[STAGES-2].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_done <= 1'b0;
    end else begin
      rst_done <= stage[STAGES-1] & ~stage[STAGES-2];
    end
  end
`endif

endmodule

// File: tb/tb_rst_sync_bridge.sv
// Self-checking bench for rst_sync_bridge at depths 2, 4 and 8 sharing one clk/rst.
// Expected values are queued as stimulus is applied and compared as outputs are sampled.
module tb_rst_sync_bridge;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } sb_entry_t;

  sb_entry_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  logic clk = 1'b0;
  logic clk_en = 1'b1;
  logic rst = 1'b0;

  logic sr2, srn2, sr4, srn4, sr8, srn8;
`ifdef RST_SYNC_DONE_PULSE_EN
  logic done2, done4, done8;
`endif

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  rst_sync_bridge #(.NUM_STAGES(2)) dut2 (
    .clk(clk), .rst(rst), .sync_rst(sr2), .sync_rst_n(srn2)
`ifdef RST_SYNC_DONE_PULSE_EN
    , .rst_done(done2)
`endif
  );

  rst_sync_bridge #(.NUM_STAGES(4)) dut4 (
    .clk(clk), .rst(rst), .sync_rst(sr4), .sync_rst_n(srn4)
`ifdef RST_SYNC_DONE_PULSE_EN
    , .rst_done(done4)
`endif
  );

  rst_sync_bridge #(.NUM_STAGES(8)) dut8 (
    .clk(clk), .rst(rst), .sync_rst(sr8), .sync_rst_n(srn8)
`ifdef RST_SYNC_DONE_PULSE_EN
    , .rst_done(done8)
`endif
  );

  task automatic push_exp(input string tag, input logic [31:0] value);
    sb_entry_t e;
    e.tag   = tag;
    e.value = value;
    sb.push_back(e);
  endtask

  task automatic check_pop(input logic [31:0] observed);
    sb_entry_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_underflow observed=%0d expected=<none>", observed);
    end else begin
      e = sb.pop_front();
      assert (observed === e.value)
      else begin
        miscompares++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, observed, e.value);
      end
    end
  endtask

  // Output levels of all three instances against one expected reset level.
  task automatic check_levels(input string tag, input logic level);
    push_exp({tag, "_sr2"},  {31'b0, level});
    push_exp({tag, "_srn2"}, {31'b0, ~level});
    push_exp({tag, "_sr4"},  {31'b0, level});
    push_exp({tag, "_srn4"}, {31'b0, ~level});
    push_exp({tag, "_sr8"},  {31'b0, level});
    push_exp({tag, "_srn8"}, {31'b0, ~level});
    check_pop({31'b0, sr2});
    check_pop({31'b0, srn2});
    check_pop({31'b0, sr4});
    check_pop({31'b0, srn4});
    check_pop({31'b0, sr8});
    check_pop({31'b0, srn8});
`ifdef RST_SYNC_DONE_PULSE_EN
    if (level) begin
      push_exp({tag, "_done4_in_reset"}, 32'd0);
      check_pop({31'b0, done4});
    end
`endif
  endtask

  // Drops rst now and records on which edge after release each output falls.
  task automatic release_and_check(input string tag);
    int e2, e4, e8, bounce, done_edge, done_count;
    push_exp({tag, "_edges_n2"}, 32'd2);
    push_exp({tag, "_edges_n4"}, 32'd4);
    push_exp({tag, "_edges_n8"}, 32'd8);
    push_exp({tag, "_bounce"},   32'd0);
`ifdef RST_SYNC_DONE_PULSE_EN
    push_exp({tag, "_done_edge"},  32'd4);
    push_exp({tag, "_done_count"}, 32'd1);
`endif
    rst = 1'b0;
    e2 = 0; e4 = 0; e8 = 0; bounce = 0; done_edge = 0; done_count = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (e2 == 0) begin
        if (sr2 === 1'b0) e2 = k;
      end else if (sr2 !== 1'b0) bounce++;
      if (e4 == 0) begin
        if (sr4 === 1'b0) e4 = k;
      end else if (sr4 !== 1'b0) bounce++;
      if (e8 == 0) begin
        if (sr8 === 1'b0) e8 = k;
      end else if (sr8 !== 1'b0) bounce++;
`ifdef RST_SYNC_DONE_PULSE_EN
      if (done4 === 1'b1) begin
        done_count++;
        if (done_edge == 0) done_edge = k;
      end
`endif
    end
    check_pop(e2);
    check_pop(e4);
    check_pop(e8);
    check_pop(bounce);
`ifdef RST_SYNC_DONE_PULSE_EN
    check_pop(done_edge);
    check_pop(done_count);
`endif
    check_levels({tag, "_settled"}, 1'b0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset held: outputs asserted with clk running and with clk stopped.
    #1 rst = 1'b1;
    repeat (4) begin
      #50;
      check_levels("reset_hold", 1'b1);
    end
    @(negedge clk);
    clk_en = 1'b0;
    #100;
    check_levels("reset_clk_stopped", 1'b1);
    clk_en = 1'b1;

    // First release 5 ns before a rising edge.
    @(posedge clk);
    #5;
    release_and_check("release1");

    // Mid-cycle assertion with no clk edge, then two more releases back to back.
    #4 rst = 1'b1;
    #1 check_levels("assert_async1", 1'b1);
    @(posedge clk);
    #5;
    release_and_check("release2");
    #4 rst = 1'b1;
    #1 check_levels("assert_async2", 1'b1);
    @(posedge clk);
    #5;
    release_and_check("release3");

    // Re-assertion while the release is still propagating.
    #4 rst = 1'b1;
    #1 check_levels("pre_reassert", 1'b1);
    @(posedge clk);
    #5 rst = 1'b0;
    @(posedge clk);
    #1;
    push_exp("reassert_e1_sr4", 32'd1);
    push_exp("reassert_e1_sr8", 32'd1);
    check_pop({31'b0, sr4});
    check_pop({31'b0, sr8});
    @(posedge clk);
    #1;
    push_exp("reassert_e2_sr2", 32'd0);
    push_exp("reassert_e2_sr4", 32'd1);
    push_exp("reassert_e2_sr8", 32'd1);
    check_pop({31'b0, sr2});
    check_pop({31'b0, sr4});
    check_pop({31'b0, sr8});
    #3 rst = 1'b1;
    #1 check_levels("reassert_mid", 1'b1);
    @(posedge clk);
    #1 check_levels("reassert_hold", 1'b1);
    #4;
    release_and_check("release_after_reassert");

    // 1 ns glitch on rst while released.
    #4 rst = 1'b1;
    #1 check_levels("glitch", 1'b1);
    release_and_check("glitch_release");

    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
